// File: rtl/i2c_defs.sv
// Shared definitions for the PCF8574-style I2C target: FSM states, bus levels
// and the position of the R/W bit in the address byte.
package i2c_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_IGNORE
  } state_e;

  localparam logic        SDA_ACK  = 1'b0;
  localparam logic        SDA_NACK = 1'b1;
  localparam int unsigned RW_BIT   = 0;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for an asynchronous bus line followed by a one-flop
// edge register; yields the synchronized level and single-clk edge pulses.
module i2c_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  // Reset to the idle-high bus level so no edge is reported on reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      edge_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~edge_q;
  assign fall_o  = ~level_o & edge_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target emulating a PCF8574 8-bit port expander: written bytes land on
// port_out, reads return port_in sampled at each byte's load point.
module i2c_target
  import i2c_defs::*;
#(
  parameter logic [6:0]  ADDR        = 7'h27,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] port_out,
  input  logic [7:0] port_in,
  output logic       wr_strobe,
  output logic       rd_strobe,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic scl_pre, start_ev, stop_ev;
  logic [7:0] shift_in;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk_i   (clk),
    .rst_ni  (rst),
    .async_i (scl_in),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk_i   (clk),
    .rst_ni  (rst),
    .async_i (sda_in),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  // START/STOP are judged against SCL as it was before any coincident SCL edge.
  assign scl_pre  = scl_lvl ^ (scl_rise | scl_fall);
  assign start_ev = sda_fall & scl_pre;
  assign stop_ev  = sda_rise & scl_pre;

  state_e     state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       flag_q, flag_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] port_out_q, port_out_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       rd_strobe_q, rd_strobe_d;
  logic       busy_q, busy_d;

  assign shift_in = {shift_q[6:0], sda_lvl};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      flag_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      port_out_q  <= '1;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      flag_q      <= flag_d;
      sda_oe_q    <= sda_oe_d;
      port_out_q  <= port_out_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      busy_q      <= busy_d;
    end
  end

  // flag_q marks "8th bit sampled, act on the next SCL fall" in ADDR/WRITE,
  // and "master ACKed" in READ_ACK.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    flag_d      = flag_q;
    sda_oe_d    = sda_oe_q;
    port_out_d  = port_out_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    busy_d      = busy_q;

    if (stop_ev) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      flag_d   = 1'b0;
    end else if (start_ev) begin
      state_d  = ST_ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
      flag_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ADDR: begin
          if (scl_rise && !flag_q) begin
            shift_d  = shift_in;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              if (shift_in[7:1] == ADDR && ADDR != '0) begin
                rw_d   = shift_in[RW_BIT];
                flag_d = 1'b1;
              end else begin
                state_d = ST_IGNORE;
                busy_d  = 1'b0;
              end
            end
          end else if (scl_fall && flag_q) begin
            state_d  = ST_ADDR_ACK;
            flag_d   = 1'b0;
            sda_oe_d = ~SDA_ACK;
            busy_d   = 1'b1;
            if (rw_q) begin
              shift_d     = port_in;
              rd_strobe_d = 1'b1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bitcnt_d = '0;
            if (rw_q) begin
              state_d  = ST_READ;
              sda_oe_d = ~shift_q[7];
            end else begin
              state_d  = ST_WRITE;
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_WRITE: begin
          if (scl_rise && !flag_q) begin
            shift_d  = shift_in;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) flag_d = 1'b1;
          end else if (scl_fall && flag_q) begin
            port_out_d  = shift_q;
            wr_strobe_d = 1'b1;
            sda_oe_d    = ~SDA_ACK;
            state_d     = ST_WRITE_ACK;
            flag_d      = 1'b0;
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_WRITE;
            bitcnt_d = '0;
          end
        end
        ST_READ: begin
          if (scl_fall) begin
            if (bitcnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = ST_READ_ACK;
              flag_d   = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end
        end
        ST_READ_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == SDA_NACK) begin
              state_d  = ST_IGNORE;
              sda_oe_d = 1'b0;
            end else begin
              flag_d = 1'b1;
            end
          end else if (scl_fall && flag_q) begin
            shift_d     = port_in;
            rd_strobe_d = 1'b1;
            sda_oe_d    = ~port_in[7];
            state_d     = ST_READ;
            bitcnt_d    = '0;
            flag_d      = 1'b0;
          end
        end
        ST_IGNORE: sda_oe_d = 1'b0;
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign port_out  = port_out_q;
  assign wr_strobe = wr_strobe_q;
  assign rd_strobe = rd_strobe_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C master driving i2c_target, checked against a transaction-level
// model of the expander (address match, port value, strobe counts, read data).
module tb_i2c_target;

  localparam logic [6:0] TGT = 7'h27;
  localparam int Q = 100;  // quarter SCL period = 10 clks

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] port_out;
  logic [7:0] port_in_r = 8'h00;
  logic       wr_strobe, rd_strobe, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int scl_high_changes = 0;
  logic oe_prev = 1'b0;
  logic oe_mid;
  logic [7:0] exp_port = 8'hFF;
  logic [7:0] wq[$];

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.ADDR(TGT), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .port_out  (port_out),
    .port_in   (port_in_r),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .busy      (busy)
  );

  always @(posedge clk) begin
    if (wr_strobe) wr_cnt++;
    if (rd_strobe) rd_cnt++;
    if (sda_oe !== oe_prev && scl_m) scl_high_changes++;
    oe_prev = sda_oe;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_cond();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    #Q; sda_m = 1'b0;
    #Q; scl_m = 1'b1;
    #Q; sda_m = 1'b1;
    #Q;
  endtask

  task automatic bit_cycle(input logic b, output logic seen);
    #Q; sda_m = b;
    #Q; scl_m = 1'b1;
    #Q; seen = sda_line; oe_mid = sda_oe;
    #Q; scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], dummy);
    bit_cycle(1'b1, ack);
  endtask

  // port_in changes after the MSB so each byte shows which value was captured.
  task automatic read_byte(input logic ack_val, output logic [7:0] b);
    logic dummy;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, dummy);
      b[i] = dummy;
      if (i == 7) port_in_r = 8'($urandom);
    end
    bit_cycle(ack_val, dummy);
  endtask

  task automatic do_txn(input logic [6:0] a, input logic rw, input int n, input logic partial);
    logic       match, ack;
    logic [7:0] d, got, cap;
    int         wr0, rd0, exp_wr, exp_rd;
    match  = (a == TGT);
    wr0    = wr_cnt;
    rd0    = rd_cnt;
    exp_wr = 0;
    exp_rd = 0;
    cap    = port_in_r;
    start_cond();
    write_byte({a, rw}, ack);
    check_eq("addr_ack", ack, match ? 0 : 1);
    check_eq("busy_after_addr", busy, match);
    if (!rw) begin
      for (int k = 0; k < n; k++) begin
        d = (wq.size() > 0) ? wq.pop_front() : 8'($urandom);
        write_byte(d, ack);
        check_eq("data_ack", ack, match ? 0 : 1);
        if (match) begin
          exp_port = d;
          exp_wr++;
        end
        check_eq("port_out", port_out, exp_port);
      end
    end else begin
      if (match) exp_rd++;
      for (int k = 0; k < n; k++) begin
        read_byte(k == n - 1, got);
        check_eq("read_byte", got, match ? cap : 8'hFF);
        if (k == n - 1) check_eq("nack_release", oe_mid, 0);
        else if (match) exp_rd++;
        cap = port_in_r;
      end
    end
    if (partial) begin
      for (int i = 0; i < 4; i++) bit_cycle(1'($urandom), ack);
    end else begin
      stop_cond();
      check_eq("busy_after_stop", busy, 0);
    end
    check_eq("port_out_end", port_out, exp_port);
    check_eq("wr_strobes", wr_cnt - wr0, exp_wr);
    check_eq("rd_strobes", rd_cnt - rd0, exp_rd);
  endtask

  task automatic reset_mid_read();
    logic ack;
    port_in_r = 8'h3C;
    start_cond();
    write_byte({TGT, 1'b1}, ack);
    check_eq("rst_addr_ack", ack, 0);
    #Q;
    check_eq("rst_pre_drive", sda_oe, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_async_release", sda_oe, 0);
    check_eq("rst_port_out", port_out, 8'hFF);
    check_eq("rst_busy", busy, 0);
    exp_port = 8'hFF;
    #Q; sda_m = 1'b1; scl_m = 1'b1;
    #Q; rst = 1'b1;
    #(2 * Q);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] a;
    #23;
    check_eq("reset_sda_oe", sda_oe, 0);
    check_eq("reset_port_out", port_out, 8'hFF);
    check_eq("reset_wr_strobe", wr_strobe, 0);
    check_eq("reset_rd_strobe", rd_strobe, 0);
    check_eq("reset_busy", busy, 0);
    rst = 1'b1;
    #(4 * Q);

    wq.push_back(8'hA5);
    do_txn(TGT, 1'b0, 1, 1'b0);
    wq.push_back(8'h55);
    do_txn(7'h50, 1'b0, 1, 1'b0);
    port_in_r = 8'h3C;
    do_txn(TGT, 1'b1, 1, 1'b0);
    wq.push_back(8'h11);
    wq.push_back(8'h22);
    do_txn(TGT, 1'b0, 2, 1'b1);
    do_txn(TGT, 1'b1, 2, 1'b0);
    check_eq("partial_discarded", port_out, 8'h22);
    do_txn(7'h00, 1'b1, 1, 1'b0);

    reset_mid_read();

    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(1, 0) == 1) a = TGT;
      else begin
        a = 7'($urandom);
        while (a == TGT) a = 7'($urandom);
      end
      port_in_r = 8'($urandom);
      do_txn(a, 1'($urandom), int'($urandom_range(3, 1)), 1'b0);
    end

    check_eq("sda_change_while_scl_high", scl_high_changes, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) that emulates a PCF8574-style 8-bit port expander, the same device an LCD1602 I2C backpack uses.
- Sits on the FPGA at the far end of the bus from our I2C master. It lets the master's write/read sequences run end to end in simulation and on hardware without an external LCD.
- Written bytes appear on a parallel output port. Reads return a sampled parallel input port.

Parameters:
- ADDR, 7'h27, 7-bit target address this block answers to.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronizers (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- rst  input  1  asynchronous, active-low reset.
- scl_in  input  1  SCL line as seen at the pad; asynchronous to clk.
- sda_in  input  1  SDA line as seen at the pad; asynchronous to clk.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- port_out  output  8  last data byte written by the master.
- port_in  input  8  value returned on reads.
- wr_strobe  output  1  one-clk pulse when port_out is updated.
- rd_strobe  output  1  one-clk pulse when port_in is captured for transmission.
- busy  output  1  high from address match until STOP, or until a START that is not addressed to us.

Behaviour:
- Reset values (rst low, asynchronous): sda_oe=0, port_out=8'hFF (PCF8574 power-on), wr_strobe=0, rd_strobe=0, busy=0, state=IDLE. Asserting rst mid-transfer releases SDA immediately, without waiting for a clk edge.
- Input conditioning:
  - scl_in and sda_in each pass through SYNC_STAGES flops, then a 1-flop edge register.
  - Bus events are seen SYNC_STAGES+1 clks after the pad changes.
- Bus events, evaluated every clk:
  - START: SDA falling while SCL high.
  - STOP: SDA rising while SCL high.
  - SCL rise: sample point. SCL fall: drive-change point.
- Event priority: STOP > START > SCL edges.
- Global transitions:
  - STOP, from any state -> IDLE; sda_oe=0; busy=0.
  - START, from any state (including repeated START mid-byte) -> ADDR; bit counter=0; sda_oe=0.
- State machine (3-bit bit counter, 8-bit shift register):
  - IDLE: wait for START.
  - ADDR:
    - Shift SDA in MSB-first on each SCL rise.
    - After the 8th rise, compare bits[7:1] with ADDR.
    - On match: record R/W=bit0; go ADDR_ACK on the next SCL fall.
    - On mismatch: go IGNORE; sda_oe stays 0 throughout.
  - ADDR_ACK:
    - On entry (the SCL fall): sda_oe=1, busy=1.
    - If R/W=1: capture port_in into the shift register at that same fall, and pulse rd_strobe.
    - On the following SCL fall: if R/W=0, sda_oe=0 and go WRITE. If R/W=1, go READ and drive the MSB (sda_oe = ~bit7).
  - WRITE:
    - Shift 8 bits on SCL rises.
    - At the SCL fall after the 8th bit: port_out <= shift register, wr_strobe pulses 1 clk, sda_oe=1, go WRITE_ACK.
  - WRITE_ACK: at the next SCL fall, sda_oe=0 and go WRITE. Multi-byte writes are unlimited; each byte overwrites port_out.
  - READ:
    - Each SCL fall drives the next bit (sda_oe = ~bit).
    - After the 8th bit's fall period, release SDA at the next fall and go READ_ACK.
  - READ_ACK:
    - Sample SDA on SCL rise.
    - ACK (0): at the next fall, re-capture port_in, pulse rd_strobe, drive the MSB, go READ.
    - NACK (1): sda_oe=0, go IGNORE.
  - IGNORE: sda_oe=0; wait for START or STOP.
- SDA-change rule: sda_oe changes only in the clk following a detected SCL fall. It never changes while synchronized SCL is high, so the block cannot create a false START/STOP. The exception is reset/STOP/START, which release SDA.
- Simultaneous SCL and SDA edges in one clk: the SDA edge is evaluated against the pre-edge SCL value (start/stop detection uses the SCL level before the edge).
- General call (address 0) is not supported; it is treated as a mismatch.

Decomposition:
- Shared package/header i2c_defs: state encodings (IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE), the ACK/NACK level constants, and the R/W bit position.
- Sub-module i2c_sync_edge: SYNC_STAGES synchronizer plus edge detector. Outputs the synchronized level plus rise and fall pulses. Instantiated once for SCL and once for SDA.

Test Plan:
- Write byte: START, 0x4E, 0xA5, STOP at 100 kHz -> SDA low during ACK bits 9 and 18; port_out=0xA5; exactly one wr_strobe; busy low after STOP.
- Address mismatch: START, 0xA0, 0x55, STOP -> sda_oe never 1; port_out stays 0xFF; wr_strobe never pulses.
- Read with NACK: port_in=0x3C, then START, 0x4F, master NACK, STOP -> bus bits 0,0,1,1,1,1,0,0; one rd_strobe; SDA released at the 9th clock.
- Multi-byte write with repeated START: START, 0x4E, 0x11, 0x22; repeated START mid-3rd-byte; 0x4F, read 2 bytes (ACK then NACK) -> port_out=0x22; 2 wr_strobes; 2 rd_strobes; the partial byte is discarded.
- Reset mid-read: assert rst while the target drives a 0 bit -> sda_oe=0 within the same clk with no clk edge required; state=IDLE; port_out=0xFF.
